multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 1, memory read/write latency in cycles; legal range 1..15.
REQ-002 Parameter INIT_SP, default 1; 1 enables the post-reset stack-pointer write cycle, 0 skips it.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 opcode  in  6  IR[31:26]; funct  in  6  IR[5:0].
REQ-006 alu_zero  in  1  ALU zero flag; alu_ovf  in  1  ALU signed-overflow flag.
REQ-007 pc_load, ins_load, mem_write, reg_write, regA_load, regB_load, aluout_load, mdr_load, epc_load  out  1 each  register/memory strobes.
REQ-008 mux_alusrcA  out  1; mux_pcin, mux_IorD, mux_regdst, mux_alusrcB, adjsz_ctrl  out  2 each; mux_mem2reg, alu_op  out  3 each  datapath selects.
REQ-009 cause  out  2  exception cause: 0 none, 1 illegal instruction, 2 overflow.
REQ-010 state_dbg  out  5  current state encoding.

Function
REQ-011 Outputs SHALL be Moore-decoded from the state register and wait counter; any output not listed for a state is 0.
REQ-012 alu_op codes: 1 add, 2 sub, 3 and, 7 set-less-than. adjsz_ctrl: 0 word, 1 byte, 2 half.
REQ-013 INIT (1 cycle): reg_write=1, mux_regdst=2, mux_mem2reg=6 -> FETCH.
REQ-014 FETCH lasts MEM_LAT cycles with mux_IorD=0; on its last cycle: ins_load=1, pc_load=1, mux_pcin=0, mux_alusrcB=1, alu_op=1 -> DECODE.
REQ-015 DECODE (1 cycle): regA_load=regB_load=1, aluout_load=1, mux_alusrcB=3, alu_op=1 (branch target) -> dispatch.
REQ-016 Dispatch: 0x00 R-type, 0x08 ADDI, 0x0F LUI, 0x23/0x21/0x20 LW/LH/LB, 0x2B/0x29/0x28 SW/SH/SB, 0x04 BEQ, 0x05 BNE, 0x02 J; any other opcode -> EXC with cause=1.
REQ-017 R-type funct 0x20/0x22/0x24/0x2A -> alu_op 1/2/3/7; other funct -> EXC, cause=1.
REQ-018 R_EXEC/ADDI_EXEC (1 cycle): mux_alusrcA=1, mux_alusrcB 0 (R) or 2 (ADDI), aluout_load=1 -> WB; if alu_ovf=1 with alu_op 1 or 2 -> EXC, cause=2, no register write.
REQ-019 WB (1 cycle): reg_write=1; mux_regdst 1 (R), 0 (ADDI/LUI/loads); mux_mem2reg 1 (ALU), 2 (LUI), 0 (loads) -> FETCH.
REQ-020 LUI goes DECODE -> WB directly.
REQ-021 ADDR (1 cycle, loads/stores): mux_alusrcA=1, mux_alusrcB=2, alu_op=1, aluout_load=1.
REQ-022 LOAD lasts MEM_LAT cycles, mux_IorD=1; mdr_load=1 on last cycle only -> WB.
REQ-023 STORE lasts MEM_LAT cycles, mux_IorD=1, mux_memdata=1, mem_write=1 every cycle -> FETCH.
REQ-024 adjsz_ctrl SHALL hold the size of the current load/store from ADDR through WB/STORE end.
REQ-025 BRANCH (1 cycle): mux_alusrcA=1, alu_op=2, mux_pcin=1; pc_load = alu_zero (BEQ) or !alu_zero (BNE) -> FETCH.
REQ-026 JUMP (1 cycle): mux_pcin=2, pc_load=1 -> FETCH.
REQ-027 EXC (1 cycle): epc_load=1, pc_load=1, mux_pcin=3, cause held -> FETCH; cause clears to 0 on the next FETCH.
REQ-028 Wait counter SHALL reload to MEM_LAT-1 on each entry to FETCH/LOAD/STORE and never wrap below 0.

Reset
REQ-029 While rst=0: all outputs 0, cause=0, counter 0, state INIT (INIT_SP=1) or FETCH (INIT_SP=0), taking effect immediately, including mid-LOAD/STORE (mem_write drops without clock).
REQ-030 First rising edge after rst deasserts SHALL execute INIT or first FETCH cycle.

Structure
REQ-031 Shared package ctrl_pkg SHALL hold the state enum, opcode/funct constants, alu_op and adjsz codes, cause codes.
REQ-032 Sub-module ctrl_wait_cnt (load, decrement, last flag, width $clog2(16)) SHALL implement the memory wait counter.

Verification
REQ-033 MEM_LAT=1, INIT_SP=1, release reset -> cycle 1 reg_write=1/regdst=2/mem2reg=6, cycle 2 ins_load=pc_load=1.
REQ-034 MEM_LAT=3, LW (0x23) -> FETCH 3 cycles, mdr_load single pulse on 3rd LOAD cycle, WB reg_write=1 mem2reg=0; 10 cycles total.
REQ-035 SB (0x28), MEM_LAT=2 -> mem_write=1 for exactly 2 cycles, adjsz_ctrl=1, no reg_write.
REQ-036 BEQ with alu_zero=1 -> pc_load=1 mux_pcin=1; BNE with alu_zero=1 -> pc_load=0.
REQ-037 opcode 0x3F -> EXC, cause=1, epc_load=pc_load=1, mux_pcin=3; R-type add with alu_ovf=1 -> cause=2, reg_write never asserted.
REQ-038 rst low during STORE -> mem_write=0 asynchronously; after release, normal INIT/FETCH sequence.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcode/funct
// constants, ALU/size/cause codes and small decode helpers.
package ctrl_pkg;

  // Controller states; the encoding is visible on state_dbg.
  typedef enum logic [4:0] {
    StInit     = 5'd0,
    StFetch    = 5'd1,
    StDecode   = 5'd2,
    StRExec    = 5'd3,
    StAddiExec = 5'd4,
    StWb       = 5'd5,
    StAddr     = 5'd6,
    StLoad     = 5'd7,
    StStore    = 5'd8,
    StBranch   = 5'd9,
    StJump     = 5'd10,
    StExc      = 5'd11
  } state_e;

  // Instruction class remembered from DECODE for the later states.
  typedef enum logic [2:0] {
    KindR,
    KindAddi,
    KindLui,
    KindLoad,
    KindStore,
    KindBeq,
    KindBne,
    KindJump
  } kind_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLb    = 6'h20;
  localparam logic [5:0] OpLh    = 6'h21;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSb    = 6'h28;
  localparam logic [5:0] OpSh    = 6'h29;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnSlt = 6'h2A;

  // ALU operation codes; AluNone doubles as "illegal funct".
  localparam logic [2:0] AluNone = 3'd0;
  localparam logic [2:0] AluAdd  = 3'd1;
  localparam logic [2:0] AluSub  = 3'd2;
  localparam logic [2:0] AluAnd  = 3'd3;
  localparam logic [2:0] AluSlt  = 3'd7;

  // Memory access size for the byte/half adjust unit
  localparam logic [1:0] SzWord = 2'd0;
  localparam logic [1:0] SzByte = 2'd1;
  localparam logic [1:0] SzHalf = 2'd2;

  // Exception causes
  localparam logic [1:0] CauseNone    = 2'd0;
  localparam logic [1:0] CauseIllegal = 2'd1;
  localparam logic [1:0] CauseOvf     = 2'd2;

  // PC input select
  localparam logic [1:0] PcinAlu    = 2'd0;
  localparam logic [1:0] PcinAluOut = 2'd1;
  localparam logic [1:0] PcinJump   = 2'd2;
  localparam logic [1:0] PcinExc    = 2'd3;

  // Wait counter covers latencies up to 15 cycles.
  localparam int unsigned CntWidth = $clog2(16);

  // Map an R-type funct to its ALU op; AluNone marks an unsupported funct.
  function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
    logic [2:0] op;
    case (funct)
      FnAdd:   op = AluAdd;
      FnSub:   op = AluSub;
      FnAnd:   op = AluAnd;
      FnSlt:   op = AluSlt;
      default: op = AluNone;
    endcase
    return op;
  endfunction

  // Access size of a load/store opcode.
  function automatic logic [1:0] mem_size(input logic [5:0] opcode);
    logic [1:0] sz;
    case (opcode)
      OpLb, OpSb: sz = SzByte;
      OpLh, OpSh: sz = SzHalf;
      default:    sz = SzWord;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Memory wait counter: loads a start value, counts down to zero and holds
// there; last is high while the count is zero.
module ctrl_wait_cnt
  import ctrl_pkg::*;
#(
  parameter int unsigned Width = CntWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic [Width-1:0] cnt,
  output logic             last
);

  logic [Width-1:0] cnt_q;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit. Single FSM register plus a memory wait
// counter; datapath strobes and selects are decoded from the current state.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned INIT_SP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  output logic       pc_load,
  output logic       ins_load,
  output logic       mem_write,
  output logic       reg_write,
  output logic       regA_load,
  output logic       regB_load,
  output logic       aluout_load,
  output logic       mdr_load,
  output logic       epc_load,
  output logic       mux_memdata,
  output logic       mux_alusrcA,
  output logic [1:0] mux_pcin,
  output logic [1:0] mux_IorD,
  output logic [1:0] mux_regdst,
  output logic [1:0] mux_alusrcB,
  output logic [1:0] adjsz_ctrl,
  output logic [2:0] mux_mem2reg,
  output logic [2:0] alu_op,
  output logic [1:0] cause,
  output logic [4:0] state_dbg
);

  localparam state_e ResetState = (INIT_SP != 0) ? StInit : StFetch;
  localparam logic [CntWidth-1:0] LatLoad = CntWidth'(MEM_LAT - 1);

  state_e        state_q;
  kind_e         kind_q;
  logic [2:0]    alu_op_q;
  logic [1:0]    size_q;
  logic [1:0]    cause_q;

  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_last;
  logic [CntWidth-1:0] cnt_val;

  // Reload in every state whose successor is a counted (memory) state.
  always_comb begin
    cnt_load = 1'b0;
    case (state_q)
      StInit, StWb, StBranch, StJump, StExc, StAddr: cnt_load = 1'b1;
      StStore:                                       cnt_load = cnt_last;
      default:                                       cnt_load = 1'b0;
    endcase
    cnt_dec = (state_q == StFetch) || (state_q == StLoad) || (state_q == StStore);
  end

  ctrl_wait_cnt #(
    .Width(CntWidth)
  ) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(LatLoad),
    .dec     (cnt_dec),
    .cnt     (cnt_val),
    .last    (cnt_last)
  );

  // State register, transitions and per-instruction context.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ResetState;
      kind_q   <= KindR;
      alu_op_q <= AluNone;
      size_q   <= SzWord;
      cause_q  <= CauseNone;
    end else begin
      case (state_q)
        StInit: state_q <= StFetch;

        StFetch: begin
          if (cnt_last) state_q <= StDecode;
        end

        StDecode: begin
          case (opcode)
            OpRtype: begin
              if (funct_alu_op(funct) != AluNone) begin
                kind_q   <= KindR;
                alu_op_q <= funct_alu_op(funct);
                state_q  <= StRExec;
              end else begin
                cause_q <= CauseIllegal;
                state_q <= StExc;
              end
            end
            OpAddi: begin
              kind_q  <= KindAddi;
              state_q <= StAddiExec;
            end
            OpLui: begin
              kind_q  <= KindLui;
              state_q <= StWb;
            end
            OpLw, OpLh, OpLb: begin
              kind_q  <= KindLoad;
              size_q  <= mem_size(opcode);
              state_q <= StAddr;
            end
            OpSw, OpSh, OpSb: begin
              kind_q  <= KindStore;
              size_q  <= mem_size(opcode);
              state_q <= StAddr;
            end
            OpBeq: begin
              kind_q  <= KindBeq;
              state_q <= StBranch;
            end
            OpBne: begin
              kind_q  <= KindBne;
              state_q <= StBranch;
            end
            OpJ: begin
              kind_q  <= KindJump;
              state_q <= StJump;
            end
            default: begin
              cause_q <= CauseIllegal;
              state_q <= StExc;
            end
          endcase
        end

        // Overflow only matters for the signed add/sub operations.
        StRExec: begin
          if (alu_ovf && ((alu_op_q == AluAdd) || (alu_op_q == AluSub))) begin
            cause_q <= CauseOvf;
            state_q <= StExc;
          end else begin
            state_q <= StWb;
          end
        end

        StAddiExec: begin
          if (alu_ovf) begin
            cause_q <= CauseOvf;
            state_q <= StExc;
          end else begin
            state_q <= StWb;
          end
        end

        StWb: state_q <= StFetch;

        StAddr: state_q <= (kind_q == KindLoad) ? StLoad : StStore;

        StLoad: begin
          if (cnt_last) state_q <= StWb;
        end

        StStore: begin
          if (cnt_last) state_q <= StFetch;
        end

        StBranch: state_q <= StFetch;
        StJump:   state_q <= StFetch;

        // Cause is visible for the EXC cycle only.
        StExc: begin
          cause_q <= CauseNone;
          state_q <= StFetch;
        end

        default: state_q <= ResetState;
      endcase
    end
  end

  // Output decode; everything is forced low while reset is asserted so that
  // strobes such as mem_write drop without waiting for a clock.
  always_comb begin
    pc_load     = 1'b0;
    ins_load    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    regA_load   = 1'b0;
    regB_load   = 1'b0;
    aluout_load = 1'b0;
    mdr_load    = 1'b0;
    epc_load    = 1'b0;
    mux_memdata = 1'b0;
    mux_alusrcA = 1'b0;
    mux_pcin    = PcinAlu;
    mux_IorD    = 2'd0;
    mux_regdst  = 2'd0;
    mux_alusrcB = 2'd0;
    adjsz_ctrl  = SzWord;
    mux_mem2reg = 3'd0;
    alu_op      = AluNone;
    if (rst) begin
      case (state_q)
        // Write the initial stack pointer.
        StInit: begin
          reg_write   = 1'b1;
          mux_regdst  = 2'd2;
          mux_mem2reg = 3'd6;
        end
        StFetch: begin
          if (cnt_last) begin
            ins_load    = 1'b1;
            pc_load     = 1'b1;
            mux_pcin    = PcinAlu;
            mux_alusrcB = 2'd1;
            alu_op      = AluAdd;
          end
        end
        // Read registers and precompute the branch target.
        StDecode: begin
          regA_load   = 1'b1;
          regB_load   = 1'b1;
          aluout_load = 1'b1;
          mux_alusrcB = 2'd3;
          alu_op      = AluAdd;
        end
        StRExec: begin
          mux_alusrcA = 1'b1;
          mux_alusrcB = 2'd0;
          aluout_load = 1'b1;
          alu_op      = alu_op_q;
        end
        StAddiExec: begin
          mux_alusrcA = 1'b1;
          mux_alusrcB = 2'd2;
          aluout_load = 1'b1;
          alu_op      = AluAdd;
        end
        StWb: begin
          reg_write = 1'b1;
          case (kind_q)
            KindR: begin
              mux_regdst  = 2'd1;
              mux_mem2reg = 3'd1;
            end
            KindAddi: mux_mem2reg = 3'd1;
            KindLui:  mux_mem2reg = 3'd2;
            KindLoad: begin
              mux_mem2reg = 3'd0;
              adjsz_ctrl  = size_q;
            end
            default: mux_mem2reg = 3'd0;
          endcase
        end
        StAddr: begin
          mux_alusrcA = 1'b1;
          mux_alusrcB = 2'd2;
          alu_op      = AluAdd;
          aluout_load = 1'b1;
          adjsz_ctrl  = size_q;
        end
        StLoad: begin
          mux_IorD   = 2'd1;
          adjsz_ctrl = size_q;
          mdr_load   = cnt_last;
        end
        StStore: begin
          mux_IorD    = 2'd1;
          mux_memdata = 1'b1;
          mem_write   = 1'b1;
          adjsz_ctrl  = size_q;
        end
        StBranch: begin
          mux_alusrcA = 1'b1;
          alu_op      = AluSub;
          mux_pcin    = PcinAluOut;
          pc_load     = (kind_q == KindBne) ? !alu_zero : alu_zero;
        end
        StJump: begin
          mux_pcin = PcinJump;
          pc_load  = 1'b1;
        end
        StExc: begin
          epc_load = 1'b1;
          pc_load  = 1'b1;
          mux_pcin = PcinExc;
        end
        default: ;
      endcase
    end
  end

  assign cause     = cause_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: four instances (MEM_LAT 1/2/3 with INIT_SP=1,
// MEM_LAT 1 with INIT_SP=0) checked cycle by cycle against per-instruction
// expected output sequences.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_load;
    logic       ins_load;
    logic       mem_write;
    logic       reg_write;
    logic       rega;
    logic       regb;
    logic       aluout;
    logic       mdr;
    logic       epc;
    logic       memdata;
    logic       srca;
    logic [1:0] pcin;
    logic [1:0] iord;
    logic [1:0] regdst;
    logic [1:0] srcb;
    logic [1:0] adjsz;
    logic [2:0] mem2reg;
    logic [2:0] aluop;
    logic [1:0] cause;
  } ovec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] op_a   [4];
  logic [5:0] fn_a   [4];
  logic       zero_a [4];
  logic       ovf_a  [4];
  ovec_t      obs    [4];
  logic [4:0] dbg    [4];

  int    n_checks = 0;
  int    n_errs   = 0;
  ovec_t exp_q[$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned Ml  = (g < 3) ? g + 1 : 1;
    localparam int unsigned Isp = (g == 3) ? 0 : 1;
    logic       pc_load, ins_load, mem_write, reg_write, rega, regb, aluout, mdr, epc;
    logic       memdata, srca;
    logic [1:0] pcin, iord, regdst, srcb, adjsz, cause;
    logic [2:0] mem2reg, aluop;
    logic [4:0] state_dbg;

    multicycle_ctrl #(
      .MEM_LAT(Ml),
      .INIT_SP(Isp)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (op_a[g]),
      .funct      (fn_a[g]),
      .alu_zero   (zero_a[g]),
      .alu_ovf    (ovf_a[g]),
      .pc_load    (pc_load),
      .ins_load   (ins_load),
      .mem_write  (mem_write),
      .reg_write  (reg_write),
      .regA_load  (rega),
      .regB_load  (regb),
      .aluout_load(aluout),
      .mdr_load   (mdr),
      .epc_load   (epc),
      .mux_memdata(memdata),
      .mux_alusrcA(srca),
      .mux_pcin   (pcin),
      .mux_IorD   (iord),
      .mux_regdst (regdst),
      .mux_alusrcB(srcb),
      .adjsz_ctrl (adjsz),
      .mux_mem2reg(mem2reg),
      .alu_op     (aluop),
      .cause      (cause),
      .state_dbg  (state_dbg)
    );

    assign obs[g] = {pc_load, ins_load, mem_write, reg_write, rega, regb, aluout, mdr, epc,
                     memdata, srca, pcin, iord, regdst, srcb, adjsz, mem2reg, aluop, cause};
    assign dbg[g] = state_dbg;
  end

  function automatic int ml_of(input int k);
    return (k < 3) ? k + 1 : 1;
  endfunction

  function automatic int isp_of(input int k);
    return (k == 3) ? 0 : 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: expected per-cycle outputs ----------------
  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'd1;
      6'h22:   return 3'd2;
      6'h24:   return 3'd3;
      6'h2A:   return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] size_of(input logic [5:0] op);
    case (op)
      6'h20, 6'h28: return 2'd1;
      6'h21, 6'h29: return 2'd2;
      default:      return 2'd0;
    endcase
  endfunction

  function automatic ovec_t init_vec();
    ovec_t v = '0;
    v.reg_write = 1'b1;
    v.regdst    = 2'd2;
    v.mem2reg   = 3'd6;
    return v;
  endfunction

  function automatic ovec_t fetch_vec(input bit last);
    ovec_t v = '0;
    if (last) begin
      v.ins_load = 1'b1;
      v.pc_load  = 1'b1;
      v.srcb     = 2'd1;
      v.aluop    = 3'd1;
    end
    return v;
  endfunction

  task automatic push_exc(input logic [1:0] c);
    ovec_t v = '0;
    v.epc     = 1'b1;
    v.pc_load = 1'b1;
    v.pcin    = 2'd3;
    v.cause   = c;
    exp_q.push_back(v);
  endtask

  task automatic push_wb(input logic [1:0] rd, input logic [2:0] m2r, input logic [1:0] sz);
    ovec_t v = '0;
    v.reg_write = 1'b1;
    v.regdst    = rd;
    v.mem2reg   = m2r;
    v.adjsz     = sz;
    exp_q.push_back(v);
  endtask

  task automatic push_addr(input logic [1:0] sz);
    ovec_t v = '0;
    v.srca   = 1'b1;
    v.srcb   = 2'd2;
    v.aluop  = 3'd1;
    v.aluout = 1'b1;
    v.adjsz  = sz;
    exp_q.push_back(v);
  endtask

  task automatic build(input int ml, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic o);
    ovec_t      v;
    logic [2:0] a;
    logic [1:0] sz;
    exp_q.delete();
    for (int i = 0; i < ml; i++) exp_q.push_back(fetch_vec(i == ml - 1));
    v = '0; v.rega = 1'b1; v.regb = 1'b1; v.aluout = 1'b1; v.srcb = 2'd3; v.aluop = 3'd1;
    exp_q.push_back(v);
    sz = size_of(op);
    case (op)
      6'h00: begin
        a = r_alu(fn);
        if (a == 3'd0) push_exc(2'd1);
        else begin
          v = '0; v.srca = 1'b1; v.aluout = 1'b1; v.aluop = a;
          exp_q.push_back(v);
          if (o && (a == 3'd1 || a == 3'd2)) push_exc(2'd2);
          else push_wb(2'd1, 3'd1, 2'd0);
        end
      end
      6'h08: begin
        v = '0; v.srca = 1'b1; v.srcb = 2'd2; v.aluout = 1'b1; v.aluop = 3'd1;
        exp_q.push_back(v);
        if (o) push_exc(2'd2);
        else push_wb(2'd0, 3'd1, 2'd0);
      end
      6'h0F: push_wb(2'd0, 3'd2, 2'd0);
      6'h23, 6'h21, 6'h20: begin
        push_addr(sz);
        for (int i = 0; i < ml; i++) begin
          v = '0; v.iord = 2'd1; v.adjsz = sz; v.mdr = (i == ml - 1);
          exp_q.push_back(v);
        end
        push_wb(2'd0, 3'd0, sz);
      end
      6'h2B, 6'h29, 6'h28: begin
        push_addr(sz);
        for (int i = 0; i < ml; i++) begin
          v = '0; v.iord = 2'd1; v.memdata = 1'b1; v.mem_write = 1'b1; v.adjsz = sz;
          exp_q.push_back(v);
        end
      end
      6'h04, 6'h05: begin
        v = '0; v.srca = 1'b1; v.aluop = 3'd2; v.pcin = 2'd1;
        v.pc_load = (op == 6'h04) ? z : !z;
        exp_q.push_back(v);
      end
      6'h02: begin
        v = '0; v.pcin = 2'd2; v.pc_load = 1'b1;
        exp_q.push_back(v);
      end
      default: push_exc(2'd1);
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input int k, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic o);
    op_a[k] = op; fn_a[k] = fn; zero_a[k] = z; ovf_a[k] = o;
  endtask

  // Release reset away from the rising edge and check the first cycle.
  task automatic release_rst(input int k);
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (isp_of(k) != 0) check_eq($sformatf("i%0d init", k), {3'b0, obs[k]}, {3'b0, init_vec()});
    else check_eq($sformatf("i%0d boot_fetch", k), {3'b0, obs[k]}, {3'b0, fetch_vec(1'b1)});
  endtask

  task automatic boot(input int k);
    rst = 1'b0;
    #1;
    check_eq($sformatf("i%0d reset", k), {3'b0, obs[k]}, 32'd0);
    repeat (2) @(posedge clk);
    release_rst(k);
  endtask

  task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic o, input int skip);
    set_in(k, op, fn, z, o);
    build(ml_of(k), op, fn, z, o);
    for (int i = 0; i < skip; i++) void'(exp_q.pop_front());
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check_eq($sformatf("i%0d op%02h f%02h z%0d o%0d cyc%0d st%0d", k, op, fn, z, o, i, dbg[k]),
               {3'b0, obs[k]}, {3'b0, exp_q[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gen(output logic [5:0] op, output logic [5:0] fn, output logic z,
                     output logic o);
    logic [5:0] ops [13];
    logic [5:0] fns [4];
    ops = '{6'h00, 6'h08, 6'h0F, 6'h23, 6'h21, 6'h20, 6'h2B, 6'h29, 6'h28, 6'h04, 6'h05,
            6'h02, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h2A};
    op = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 12)];
    fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 3)];
    z  = 1'($urandom_range(0, 1));
    o  = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    logic [5:0] op, fn;
    logic       z, o;
    for (int k = 0; k < 4; k++) set_in(k, 6'h00, 6'h20, 1'b0, 1'b0);

    // Directed, MEM_LAT=1
    boot(0);
    run_instr(0, 6'h04, 6'h00, 1'b1, 1'b0, 0);  // BEQ taken
    run_instr(0, 6'h05, 6'h00, 1'b1, 1'b0, 0);  // BNE not taken
    run_instr(0, 6'h3F, 6'h00, 1'b0, 1'b0, 0);  // illegal opcode
    run_instr(0, 6'h00, 6'h20, 1'b0, 1'b1, 0);  // add overflow
    run_instr(0, 6'h00, 6'h2A, 1'b0, 1'b1, 0);  // slt ignores overflow
    run_instr(0, 6'h00, 6'h01, 1'b0, 1'b0, 0);  // illegal funct
    run_instr(0, 6'h0F, 6'h00, 1'b0, 1'b0, 0);  // LUI

    // Directed, MEM_LAT=3: LW
    boot(2);
    run_instr(2, 6'h23, 6'h00, 1'b0, 1'b0, 0);

    // Directed, MEM_LAT=2: SB, then reset in the middle of a store
    boot(1);
    run_instr(1, 6'h28, 6'h00, 1'b0, 1'b0, 0);
    set_in(1, 6'h2B, 6'h00, 1'b0, 1'b0);
    build(2, 6'h2B, 6'h00, 1'b0, 1'b0);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("i1 pre_rst cyc%0d", i), {3'b0, obs[1]}, {3'b0, exp_q[i]});
    end
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_store_all", {3'b0, obs[1]}, 32'd0);
    check_eq("rst_store_memwr", {31'b0, obs[1].mem_write}, 32'd0);
    repeat (2) @(posedge clk);
    release_rst(1);
    run_instr(1, 6'h08, 6'h00, 1'b0, 1'b0, 0);

    // Random instruction streams on every instance
    for (int k = 0; k < 4; k++) begin
      boot(k);
      for (int n = 0; n < 30; n++) begin
        gen(op, fn, z, o);
        run_instr(k, op, fn, z, o, (n == 0 && isp_of(k) == 0) ? ml_of(k) : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
